// File: rtl/axi4m_arb.sv
// Single-beat AXI4 master shared by instruction fetch (read-only) and the load/store unit.
// Round-robin grant in IDLE, then exactly one AR/R or AW/W/B exchange per grant.
module axi4m_arb #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      ifu_req,
    input  logic [AXI_ADDR_W-1:0]     ifu_addr,
    output logic                      ifu_done,
    output logic                      ifu_err,
    output logic [AXI_DATA_W-1:0]     ifu_rdata,

    input  logic                      lsu_req,
    input  logic                      lsu_we,
    input  logic [AXI_ADDR_W-1:0]     lsu_addr,
    input  logic [AXI_DATA_W-1:0]     lsu_wdata,
    input  logic [AXI_DATA_W/8-1:0]   lsu_wstrb,
    output logic                      lsu_done,
    output logic                      lsu_err,
    output logic [AXI_DATA_W-1:0]     lsu_rdata,

    output logic [AXI_ADDR_W-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awlock,
    output logic [3:0]                m_axi_awcache,
    output logic [2:0]                m_axi_awprot,
    output logic [3:0]                m_axi_awqos,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,

    output logic [AXI_DATA_W-1:0]     m_axi_wdata,
    output logic [AXI_DATA_W/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,

    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,

    output logic [AXI_ADDR_W-1:0]     m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arlock,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic [3:0]                m_axi_arqos,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,

    input  logic [AXI_DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam int         STRB_W   = AXI_DATA_W / 8;
    localparam logic [2:0] AXI_SIZE = 3'($clog2(STRB_W));

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AWW, S_B, S_RSP} state_t;
    typedef enum logic {REQ_IFU, REQ_LSU} req_t;

    state_t              state, state_nxt;
    req_t                grant, rr_last, grant_nxt;
    logic                any_req, lsu_wr;
    logic                aw_done, w_done, err_q;
    logic [AXI_ADDR_W-1:0] addr_q;
    logic [AXI_DATA_W-1:0] wdata_q, ifu_rdata_q, lsu_rdata_q;
    logic [STRB_W-1:0]     wstrb_q;

    // Single-beat transfers: last flag and the low response bit carry no extra information.
    logic unused_in;
    assign unused_in = ^{m_axi_rlast, m_axi_rresp[0], m_axi_bresp[0]};

    // Contention goes to whichever requester was not served last.
    always_comb begin
        any_req = ifu_req || lsu_req;
        if (ifu_req && lsu_req) begin
            grant_nxt = (rr_last == REQ_IFU) ? REQ_LSU : REQ_IFU;
        end else if (lsu_req) begin
            grant_nxt = REQ_LSU;
        end else begin
            grant_nxt = REQ_IFU;
        end
        lsu_wr = (grant_nxt == REQ_LSU) && lsu_we;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
        if (!rst_n) begin
            state       <= S_IDLE;
            grant       <= REQ_IFU;
            rr_last     <= REQ_IFU;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            err_q       <= 1'b0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        grant   <= grant_nxt;
                        rr_last <= grant_nxt;
                        addr_q  <= (grant_nxt == REQ_LSU) ? lsu_addr : ifu_addr;
                        wdata_q <= lsu_wr ? lsu_wdata : '0;
                        wstrb_q <= lsu_wr ? lsu_wstrb : '0;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                S_AWW: begin
                    if (m_axi_awready) aw_done <= 1'b1;
                    if (m_axi_wready)  w_done  <= 1'b1;
                end
                S_R: begin
                    if (m_axi_rvalid) begin
                        err_q <= m_axi_rresp[1];
                        if (grant == REQ_IFU) ifu_rdata_q <= m_axi_rdata;
                        else                  lsu_rdata_q <= m_axi_rdata;
                    end
                end
                S_B: begin
                    if (m_axi_bvalid) err_q <= m_axi_bresp[1];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            S_IDLE: if (any_req) state_nxt = lsu_wr ? S_AWW : S_AR;
            S_AR:   if (m_axi_arready) state_nxt = S_R;
            S_R:    if (m_axi_rvalid)  state_nxt = S_RSP;
            // Either channel may already be done or be finishing this very cycle.
            S_AWW:  if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) state_nxt = S_B;
            S_B:    if (m_axi_bvalid)  state_nxt = S_RSP;
            S_RSP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        m_axi_arvalid = (state == S_AR);
        m_axi_rready  = (state == S_R);
        m_axi_awvalid = (state == S_AWW) && !aw_done;
        m_axi_wvalid  = (state == S_AWW) && !w_done;
        m_axi_wlast   = m_axi_wvalid;
        m_axi_bready  = (state == S_B);
        ifu_done      = (state == S_RSP) && (grant == REQ_IFU);
        lsu_done      = (state == S_RSP) && (grant == REQ_LSU);
        ifu_err       = ifu_done && err_q;
        lsu_err       = lsu_done && err_q;
    end

    assign ifu_rdata     = ifu_rdata_q;
    assign lsu_rdata     = lsu_rdata_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;

    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = AXI_SIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arqos   = 4'd0;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = AXI_SIZE;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'd0;

endmodule

// File: tb/tb_axi4m_arb.sv
// Bench for axi4m_arb: stalling AXI slave with a word memory, protocol monitor,
// directed vector table, round-robin / reset sequences and a randomized scoreboard run.
module tb_axi4m_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic ifu_req = 1'b0, ifu_done, ifu_err;
    logic [AW-1:0] ifu_addr = '0;
    logic [DW-1:0] ifu_rdata;
    logic lsu_req = 1'b0, lsu_we = 1'b0, lsu_done, lsu_err;
    logic [AW-1:0] lsu_addr = '0;
    logic [DW-1:0] lsu_wdata = '0, lsu_rdata;
    logic [SW-1:0] lsu_wstrb = '0;

    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0] m_axi_awlen, m_axi_arlen;
    logic [2:0] m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
    logic [1:0] m_axi_awburst, m_axi_arburst;
    logic m_axi_awlock, m_axi_arlock;
    logic [3:0] m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos;
    logic m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic [DW-1:0] m_axi_wdata;
    logic [SW-1:0] m_axi_wstrb;
    logic m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
    logic m_axi_arready = 1'b0, m_axi_rvalid = 1'b0, m_axi_rlast = 1'b0;
    logic [1:0] m_axi_bresp = '0, m_axi_rresp = '0;
    logic [DW-1:0] m_axi_rdata = '0;

    axi4m_arb #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_done(ifu_done), .ifu_err(ifu_err), .ifu_rdata(ifu_rdata),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_done(lsu_done), .lsu_err(lsu_err), .lsu_rdata(lsu_rdata),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
        .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache),
        .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    int ar_w = 0, r_w = 0, aw_w = 0, w_w = 0, b_w = 0;
    bit ar_fire = 0, r_fire = 0, aw_fire = 0, w_fire = 0, b_fire = 0;
    bit rd_busy = 0, aw_got = 0, w_got = 0;
    logic [AW-1:0] rd_addr = '0, wr_addr = '0, seen_araddr = '0, seen_awaddr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [SW-1:0] wr_strb = '0;
    logic          seen_wlast = 1'b0;
    logic [DW-1:0] mem     [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    function automatic bit err_region(input logic [AW-1:0] a);
        return a[31:28] == 4'hE;
    endfunction

    function automatic logic [DW-1:0] slave_rd(input logic [AW-1:0] a);
        logic [AW-1:0] k;
        k = {a[AW-1:2], 2'b00};
        if (err_region(a))     return '0;
        if (mem.exists(k))     return mem[k];
        return ~k;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        logic [AW-1:0] k;
        k = {a[AW-1:2], 2'b00};
        if (ref_mem.exists(k)) return ref_mem[k];
        return ~k;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [SW-1:0] strb);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < SW; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Slave drives on the falling edge; *_fire flags record what the next rising edge will accept.
    initial begin : slave
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_axi_arready = 0; m_axi_rvalid = 0; m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
                ar_fire = 0; r_fire = 0; aw_fire = 0; w_fire = 0; b_fire = 0;
                rd_busy = 0; aw_got = 0; w_got = 0;
                ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0;
            end else begin
                if (r_fire)  begin m_axi_rvalid = 0; rd_busy = 0; end
                if (b_fire)  begin m_axi_bvalid = 0; aw_got = 0; w_got = 0; end
                if (ar_fire) begin rd_busy = 1; r_w = 0; ar_w = 0; end
                if (aw_fire) begin aw_got = 1; aw_w = 0; b_w = 0; end
                if (w_fire)  begin w_got = 1; w_w = 0; b_w = 0; end

                m_axi_arready = 0;
                if (m_axi_arvalid && !rd_busy) begin
                    if (ar_w >= ar_dly) m_axi_arready = 1; else ar_w++;
                end
                m_axi_awready = 0;
                if (m_axi_awvalid && !aw_got) begin
                    if (aw_w >= aw_dly) m_axi_awready = 1; else aw_w++;
                end
                m_axi_wready = 0;
                if (m_axi_wvalid && !w_got) begin
                    if (w_w >= w_dly) m_axi_wready = 1; else w_w++;
                end
                if (rd_busy && !m_axi_rvalid) begin
                    if (r_w >= r_dly) begin
                        m_axi_rvalid = 1;
                        m_axi_rdata  = slave_rd(rd_addr);
                        m_axi_rresp  = err_region(rd_addr) ? 2'b10 : 2'b00;
                        m_axi_rlast  = 1;
                    end else r_w++;
                end
                if (aw_got && w_got && !m_axi_bvalid) begin
                    if (b_w >= b_dly) begin
                        m_axi_bvalid = 1;
                        m_axi_bresp  = err_region(wr_addr) ? 2'b10 : 2'b00;
                        if (!err_region(wr_addr))
                            mem[{wr_addr[AW-1:2], 2'b00}] = merge(slave_rd(wr_addr), wr_data, wr_strb);
                    end else b_w++;
                end

                ar_fire = m_axi_arvalid && m_axi_arready;
                r_fire  = m_axi_rvalid  && m_axi_rready;
                aw_fire = m_axi_awvalid && m_axi_awready;
                w_fire  = m_axi_wvalid  && m_axi_wready;
                b_fire  = m_axi_bvalid  && m_axi_bready;
                if (ar_fire) begin rd_addr = m_axi_araddr; seen_araddr = m_axi_araddr; end
                if (aw_fire) begin wr_addr = m_axi_awaddr; seen_awaddr = m_axi_awaddr; end
                if (w_fire)  begin wr_data = m_axi_wdata; wr_strb = m_axi_wstrb; seen_wlast = m_axi_wlast; end
            end
        end
    end

    // ---------------- protocol monitor ----------------
    initial begin : monitor
        logic p_ar, p_aw, p_w, rst_edge;
        logic [AW-1:0] p_araddr, p_awaddr;
        logic [DW-1:0] p_wdata;
        logic [SW-1:0] p_wstrb;
        p_ar = 0; p_aw = 0; p_w = 0;
        p_araddr = '0; p_awaddr = '0; p_wdata = '0; p_wstrb = '0;
        forever begin
            @(posedge clk);
            rst_edge = rst_n;
            #3;
            if (rst_edge) begin
                if (p_ar && !ar_fire) begin
                    check("arvalid held until arready", m_axi_arvalid, 1);
                    check("araddr stable under arvalid", m_axi_araddr, p_araddr);
                end
                if (p_aw && !aw_fire) begin
                    check("awvalid held until awready", m_axi_awvalid, 1);
                    check("awaddr stable under awvalid", m_axi_awaddr, p_awaddr);
                end
                if (p_w && !w_fire) begin
                    check("wvalid held until wready", m_axi_wvalid, 1);
                    check("wdata/wstrb stable under wvalid", {m_axi_wdata, m_axi_wstrb}, {p_wdata, p_wstrb});
                end
                if (p_ar && ar_fire) check("arvalid drops after handshake", m_axi_arvalid, 0);
                if (p_aw && aw_fire) check("awvalid drops after handshake", m_axi_awvalid, 0);
                if (p_w && w_fire)   check("wvalid drops after handshake", m_axi_wvalid, 0);
                if (ifu_done || lsu_done) check("single done per cycle", ifu_done & lsu_done, 0);
            end
            p_ar = m_axi_arvalid; p_araddr = m_axi_araddr;
            p_aw = m_axi_awvalid; p_awaddr = m_axi_awaddr;
            p_w  = m_axi_wvalid;  p_wdata  = m_axi_wdata; p_wstrb = m_axi_wstrb;
        end
    end

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 0; ifu_req = 0; lsu_req = 0;
        repeat (3) begin @(posedge clk); #1; end
        check("reset handshake outputs", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}, 0);
        check("reset done/err", {ifu_done, lsu_done, ifu_err, lsu_err}, 0);
        check("reset rdata", {ifu_rdata, lsu_rdata}, 0);
        check("reset addresses", {m_axi_araddr, m_axi_awaddr}, 0);
        check("reset wdata/wstrb", {m_axi_wdata, m_axi_wstrb}, 0);
        rst_n = 1;
    endtask

    task automatic run_txn(input bit lsu, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                           input logic [DW-1:0] exp_rdata, input bit exp_err,
                           input int exp_lat, input string tag);
        int cyc;
        bit got;
        @(negedge clk);
        if (lsu) begin
            lsu_req = 1; lsu_we = we; lsu_addr = addr; lsu_wdata = wdata; lsu_wstrb = strb;
        end else begin
            ifu_req = 1; ifu_addr = addr;
        end
        cyc = 0; got = 0;
        while (!got && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            if (lsu ? lsu_done : ifu_done) got = 1;
        end
        ifu_req = 0; lsu_req = 0;
        check({tag, " done seen"}, got, 1);
        if (got) begin
            check({tag, " err"}, lsu ? lsu_err : ifu_err, exp_err);
            if (!we && !exp_err) check({tag, " rdata"}, lsu ? lsu_rdata : ifu_rdata, exp_rdata);
            if (exp_lat > 0)     check({tag, " latency"}, cyc + 1, exp_lat);
            if (we) begin
                check({tag, " awaddr"}, seen_awaddr, addr);
                check({tag, " wdata/wstrb"}, {wr_data, wr_strb}, {wdata, strb});
                check({tag, " wlast"}, seen_wlast, 1);
            end else begin
                check({tag, " araddr"}, seen_araddr, addr);
            end
            @(posedge clk); #1;
            check({tag, " done one cycle"}, {ifu_done, lsu_done}, 0);
        end
    endtask

    typedef struct {
        bit            lsu;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        int            ar_d, r_d, aw_d, w_d, b_d;
        logic [DW-1:0] exp_rdata;
        bit            exp_err;
        int            exp_lat;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    initial begin : main
        int  cyc, ndone, kind;
        bit  seen, e;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;

        //              lsu we addr          wdata         strb  ar r aw w b  exp_rdata     err lat
        vecs[0]  = '{0, 0, 32'h0000_0040, 32'h0,        4'h0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 4};
        vecs[1]  = '{1, 1, 32'h0000_0100, 32'h1234_5678, 4'hF, 0, 0, 3, 0, 0, 32'h0,        0, 0};
        vecs[2]  = '{1, 0, 32'h0000_0100, 32'h0,        4'h0, 1, 2, 0, 0, 0, 32'h1234_5678, 0, 0};
        vecs[3]  = '{1, 1, 32'h0000_0100, 32'hAAAA_5555, 4'h3, 0, 0, 0, 2, 1, 32'h0,        0, 0};
        vecs[4]  = '{1, 0, 32'hE000_0010, 32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h0,        1, 0};
        vecs[5]  = '{1, 0, 32'h0000_0100, 32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h1234_5555, 0, 4};
        vecs[6]  = '{0, 0, 32'h0000_0104, 32'h0,        4'h0, 0, 0, 0, 0, 0, 32'hFFFF_FEFB, 0, 4};
        vecs[7]  = '{1, 1, 32'hE000_0000, 32'h1,        4'hF, 0, 0, 0, 0, 2, 32'h0,        1, 0};
        vecs[8]  = '{1, 1, 32'h0000_0104, 32'hCAFE_F00D, 4'hC, 0, 0, 2, 2, 0, 32'h0,        0, 0};
        vecs[9]  = '{0, 0, 32'h0000_0104, 32'h0,        4'h0, 0, 0, 0, 0, 0, 32'hCAFE_FEFB, 0, 4};
        vecs[10] = '{1, 1, 32'h0000_0108, 32'h0,        4'hF, 0, 0, 0, 0, 0, 32'h0,        0, 4};
        vecs[11] = '{1, 0, 32'h0000_0108, 32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h0,        0, 4};

        mem[32'h0000_0040] = 32'hDEAD_BEEF;

        apply_reset();
        check("fixed AR attributes", {m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
                                      m_axi_arcache, m_axi_arprot, m_axi_arqos},
              {8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'd0});
        check("fixed AW attributes", {m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock,
                                      m_axi_awcache, m_axi_awprot, m_axi_awqos},
              {8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'd0});

        for (int i = 0; i < NV; i++) begin
            ar_dly = vecs[i].ar_d; r_dly = vecs[i].r_d;
            aw_dly = vecs[i].aw_d; w_dly = vecs[i].w_d; b_dly = vecs[i].b_d;
            run_txn(vecs[i].lsu, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                    vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat, $sformatf("vec%0d", i));
        end

        // Both requesters held continuously from reset: grants alternate LSU, IFU, LSU, IFU.
        apply_reset();
        ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
        @(negedge clk);
        ifu_req = 1; ifu_addr = 32'h0000_0040;
        lsu_req = 1; lsu_we = 0; lsu_addr = 32'h0000_0100;
        cyc = 0; ndone = 0;
        while (ndone < 4 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            if (ifu_done || lsu_done) begin
                check($sformatf("rr grant %0d is lsu", ndone), lsu_done, (ndone % 2 == 0) ? 1 : 0);
                if (ifu_done) check("rr ifu rdata", ifu_rdata, 32'hDEAD_BEEF);
                if (lsu_done) check("rr lsu rdata", lsu_rdata, 32'h1234_5555);
                ndone++;
                if (ndone == 4) begin ifu_req = 0; lsu_req = 0; end
            end
        end
        ifu_req = 0; lsu_req = 0;
        check("rr grant count", ndone, 4);
        @(posedge clk); #1;
        check("rr quiet after release", {ifu_done, lsu_done}, 0);

        // Reset asserted while the read waits in R.
        ar_dly = 0; r_dly = 5;
        @(negedge clk);
        lsu_req = 1; lsu_we = 0; lsu_addr = 32'h0000_0100;
        cyc = 0; seen = 0;
        while (!seen && cyc < 50) begin
            @(posedge clk); #1; cyc++;
            if (m_axi_rready) seen = 1;
        end
        check("reset test reached R", seen, 1);
        rst_n = 0; lsu_req = 0;
        @(posedge clk); #1;
        check("mid-txn reset handshakes", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}, 0);
        check("mid-txn reset done/err", {ifu_done, lsu_done, ifu_err, lsu_err}, 0);
        check("mid-txn reset rdata", lsu_rdata, 0);
        @(posedge clk); #1;
        rst_n = 1;
        r_dly = 1;
        run_txn(1, 0, 32'h0000_0100, 32'h0, 4'h0, 32'h1234_5555, 0, 0, "post-reset read");

        // Mixed traffic with random stalls against a reference memory.
        for (int i = 0; i < 1000; i++) begin
            ar_dly = $urandom_range(0, 5); r_dly = $urandom_range(0, 5);
            aw_dly = $urandom_range(0, 5); w_dly = $urandom_range(0, 5); b_dly = $urandom_range(0, 5);
            kind = $urandom_range(0, 2);
            a = (($urandom_range(0, 15) == 0) ? 32'hE000_0000 : 32'h0000_0200) + 32'($urandom_range(0, 15)) * 4;
            d = $urandom;
            s = SW'($urandom_range(1, 15));
            e = err_region(a);
            if (kind == 2) begin
                if (!e) ref_mem[a] = merge(ref_rd(a), d, s);
                run_txn(1, 1, a, d, s, 32'h0, e, 0, $sformatf("rnd%0d wr", i));
            end else begin
                run_txn(kind == 1, 0, a, 32'h0, 4'h0, ref_rd(a), e, 0, $sformatf("rnd%0d rd", i));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
